xylo_key_encoder: RTL and testbench
===================================

Name: xylo_key_encoder

Overview:
- Upstream stage of the 7-segment note display. It feeds the 4-bit note code (a,b,c,d) consumed by the note decoder.
- Takes 8 raw, bouncing xylophone key contacts, synchronises and debounces them, and priority-encodes each new key press into a note code.
- Holds the code on the display for a programmable time after release, then drives the blank code.
- Code map: key k (0..7) -> code k+2 (0010..1001). Code 0000 = blank/idle, which the decoder renders as all segments off.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required before the debounced key vector updates. Must be >= 2.
- HOLD_CYCLES, 1000, cycles the last note stays displayed after all keys are released. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key  input  8  raw key contacts, active-high, asynchronous to clk.
- a  output  1  note code bit 3 (MSB).
- b  output  1  note code bit 2.
- c  output  1  note code bit 1.
- d  output  1  note code bit 0 (LSB).
- note_valid  output  1  high while a non-blank code is driven.
- note_strobe  output  1  one-cycle pulse when a new code is loaded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - {a,b,c,d}=0000, note_valid=0, note_strobe=0.
  - Synchronisers, candidate vector, stable vector and previous-stable vector all cleared to 0.
  - Debounce and hold counters cleared. FSM=IDLE.
  - Reset asserted mid-note blanks the outputs immediately. After reset release the block behaves as if no key was ever pressed, even if keys are held.
- Synchroniser: 2-flop per bit; sync_q is the second stage.
- Debounce (single counter, whole vector):
  - If sync_q != cand: cand<=sync_q, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=cand, cnt holds (saturates).
  - Else cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES on any bit restarts the count and never reaches stable.
- Press detect: new_press = stable & ~stable_prev; stable_prev<=stable every cycle.
  - Lowest-index set bit of new_press wins (key0 highest priority).
  - Keys already held never generate new presses.
- Latency: raw key steady before edge 0 -> outputs and strobe updated at edge DEBOUNCE_CYCLES+4.
- FSM (outputs registered):
  - IDLE: code 0000, note_valid=0.
    - new_press -> SHOW; load code, strobe=1.
  - SHOW: note_valid=1.
    - new_press -> reload code and pulse strobe, even if the code value is unchanged.
    - stable==0 with no new_press -> HOLD; hold_cnt<=HOLD_CYCLES-1.
  - HOLD: code unchanged, note_valid=1.
    - new_press -> SHOW; load code, strobe=1. Press wins over expiry in the same cycle.
    - Else if hold_cnt==0 -> IDLE; code 0000 next edge.
    - Else hold_cnt decrements.
- note_strobe is high for exactly one cycle per load and is never high in IDLE.
- Counter widths: $clog2 of each parameter, minimum 1 bit. No wrap-around: both counters saturate or reload as above.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, key=0 for 20 cycles -> {a,b,c,d}=0000, note_valid=0, no strobe.
- Press key=8'b0000_1000 steady -> at edge 8 after the change: code 0101, note_valid=1, strobe high for 1 cycle. Release -> 8 hold cycles later code 0000, note_valid=0.
- Bounce key3 high for 2 cycles, low for 1, repeated 5 times, then steady high -> exactly one strobe, code 0101, occurring 8 edges after the last bounce.
- key0 and key7 rise in the same cycle -> code 0010, one strobe. Then release key0 only and later press key0 again -> code 0010 with a second strobe. Key7 held throughout causes no strobe.
- Release all keys, then press key2 when hold_cnt reaches 0 -> code 0100, strobe, FSM stays non-idle, no 0000 cycle on the outputs.
- Assert rst_n low for 1 cycle while in SHOW with key5 held -> outputs 0000 immediately (asynchronous). After release with key5 still held, no strobe until key5 is released and pressed again.

Source files
------------

// File: rtl/xylo_key_encoder.sv
// Key front end for the note display: synchronise and debounce 8 xylophone contacts, then
// priority-encode each new press into the note code {a,b,c,d}, holding it after release.
module xylo_key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       note_valid,
    output logic       note_strobe
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StHold
    } state_e;

    logic [7:0]       sync1_q, sync_q;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       stable_q, stable_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       new_press;
    logic             primed_q, primed_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             press_q, press_d;
    logic [3:0]       press_code_q, press_code_d;
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync_q       <= '0;
            cand_q       <= '0;
            stable_q     <= '0;
            prev_q       <= '0;
            primed_q     <= 1'b0;
            db_cnt_q     <= '0;
            press_q      <= 1'b0;
            press_code_q <= '0;
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            code_q       <= '0;
            valid_q      <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            sync1_q      <= key;
            sync_q       <= sync1_q;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            primed_q     <= primed_d;
            db_cnt_q     <= db_cnt_d;
            press_q      <= press_d;
            press_code_q <= press_code_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            code_q       <= code_d;
            valid_q      <= valid_d;
            strobe_q     <= strobe_d;
        end
    end

    // One counter debounces the whole vector; any bit change restarts it.
    always_comb begin
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        prev_d   = stable_q;
        primed_d = primed_q;
        if (sync_q != cand_q) begin
            cand_d   = sync_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            stable_d = cand_q;
            // First settled vector after reset is taken as the baseline, so keys
            // held through reset never count as presses.
            if (!primed_q) begin
                primed_d = 1'b1;
                prev_d   = cand_q;
            end
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Lowest-index new press wins; registered before the display FSM.
    always_comb begin
        new_press    = stable_q & ~prev_q;
        press_d      = |new_press;
        press_code_d = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (new_press[i]) begin
                press_code_d = 4'(i + 2);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        code_d     = code_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        if (press_q) begin
            state_d  = StShow;
            code_d   = press_code_q;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    code_d  = 4'd0;
                    valid_d = 1'b0;
                end
                StShow: begin
                    if (stable_q == '0) begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLoad;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == '0) begin
                        state_d = StIdle;
                        code_d  = 4'd0;
                        valid_d = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    code_d  = 4'd0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign {a, b, c, d} = code_q;
    assign note_valid   = valid_q;
    assign note_strobe  = strobe_q;

endmodule

// File: tb/tb_xylo_key_encoder.sv
// Bench for xylo_key_encoder: directed scenarios plus random key traffic, all checked
// against a behavioural model built from sample histories rather than counters.
module tb_xylo_key_encoder;

    localparam int unsigned D = 4;
    localparam int unsigned H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] key = 8'h00;
    logic       a, b, c, d, note_valid, note_strobe;
    logic [3:0] code;

    int checks = 0;
    int errors = 0;

    xylo_key_encoder #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .note_valid (note_valid),
        .note_strobe(note_strobe)
    );

    assign code = {a, b, c, d};

    always #5 clk = ~clk;

    // Behavioural model
    typedef enum int {MIdle, MShow, MHold} mstate_e;
    mstate_e    m_state;
    int         m_hold;
    logic [3:0] m_code;
    logic       m_valid, m_strobe;
    logic [7:0] m_stable;
    bit         m_primed;
    logic [7:0] m_keys[$];
    logic [7:0] m_samp[$];
    logic [7:0] m_press[$];
    logic [7:0] m_s, m_np, m_pr;
    bit         m_settled;

    function automatic logic [3:0] note_of(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return 4'(i + 2);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_state  = MIdle;
        m_hold   = 0;
        m_code   = 4'd0;
        m_valid  = 1'b0;
        m_strobe = 1'b0;
        m_stable = 8'h00;
        m_primed = 1'b0;
        m_keys.delete();
        m_samp   = '{8'h00};
        m_press  = '{8'h00, 8'h00};
    endtask

    task automatic model_step();
        // Display reacts to the press found two edges ago and last cycle's settled keys.
        m_pr     = m_press.pop_front();
        m_strobe = 1'b0;
        if (m_pr != 8'h00) begin
            m_state  = MShow;
            m_code   = note_of(m_pr);
            m_valid  = 1'b1;
            m_strobe = 1'b1;
        end else if (m_state == MShow && m_stable == 8'h00) begin
            m_state = MHold;
            m_hold  = H - 1;
        end else if (m_state == MHold) begin
            if (m_hold == 0) begin
                m_state = MIdle;
                m_code  = 4'd0;
                m_valid = 1'b0;
            end else begin
                m_hold--;
            end
        end
        // Synchronised sample is the raw key seen two edges earlier.
        m_s = (m_keys.size() == 2) ? m_keys[0] : 8'h00;
        m_keys.push_back(key);
        if (m_keys.size() > 2) void'(m_keys.pop_front());
        m_samp.push_back(m_s);
        if (m_samp.size() > D + 1) void'(m_samp.pop_front());
        m_settled = (m_samp.size() == D + 1);
        foreach (m_samp[i]) if (m_samp[i] != m_s) m_settled = 1'b0;
        m_np = 8'h00;
        if (m_settled) begin
            if (m_primed) m_np = m_s & ~m_stable;
            m_primed = 1'b1;
            m_stable = m_s;
        end
        m_press.push_back(m_np);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic settle(input int n);
        key = 8'h00;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        key   = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            checks++;
            if (code !== 4'b0000 || note_valid !== 1'b0 || note_strobe !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle e=%0d got %b/%b/%b want 0000/0/0",
                         e, code, note_valid, note_strobe);
            end
        end
    endtask

    task automatic test_single_press();
        int ns = 0;
        key = 8'h08;
        for (int e = 0; e <= int'(D) + 6; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
            checks++;
            if (code !== m_code || note_valid !== m_valid || note_strobe !== m_strobe) begin
                errors++;
                $display("FAIL single_model e=%0d got %b/%b/%b want %b/%b/%b",
                         e, code, note_valid, note_strobe, m_code, m_valid, m_strobe);
            end
            if (e == int'(D) + 4) begin
                checks++;
                if (code !== 4'b0101 || note_valid !== 1'b1 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency got %b/%b/%b want 0101/1/1",
                             code, note_valid, note_strobe);
                end
            end
        end
        checks++;
        if (ns !== 1) begin
            errors++;
            $display("FAIL single_strobes got %0d want 1", ns);
        end
        key = 8'h00;
        for (int e = 0; e <= int'(D + H) + 5; e++) begin
            tick();
            if (e == int'(D + H) + 2) begin
                checks++;
                if (code !== 4'b0101 || note_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_last got %b/%b want 0101/1", code, note_valid);
                end
            end
            if (e == int'(D + H) + 3) begin
                checks++;
                if (code !== 4'b0000 || note_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_expire got %b/%b want 0000/0", code, note_valid);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int ns = 0;
        for (int i = 0; i < 15; i++) begin
            key = (i % 3 < 2) ? 8'h08 : 8'h00;
            tick();
            if (note_strobe === 1'b1) ns++;
        end
        key = 8'h08;
        for (int e = 0; e <= int'(D) + 6; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
            if (e == int'(D) + 4) begin
                checks++;
                if (code !== 4'b0101 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_latency got %b/%b want 0101/1", code, note_strobe);
                end
            end
        end
        checks++;
        if (ns !== 1) begin
            errors++;
            $display("FAIL bounce_strobes got %0d want 1", ns);
        end
    endtask

    task automatic test_chord();
        int ns = 0;
        key = 8'h81;
        for (int e = 0; e <= int'(D) + 6; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
            if (e == int'(D) + 4) begin
                checks++;
                if (code !== 4'b0010 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL chord_first got %b/%b want 0010/1", code, note_strobe);
                end
            end
        end
        key = 8'h80;
        for (int e = 0; e <= int'(D) + 7; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
        end
        checks++;
        if (code !== 4'b0010 || note_valid !== 1'b1) begin
            errors++;
            $display("FAIL chord_key7_held got %b/%b want 0010/1", code, note_valid);
        end
        key = 8'h81;
        for (int e = 0; e <= int'(D) + 6; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
            if (e == int'(D) + 4) begin
                checks++;
                if (code !== 4'b0010 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL chord_repress got %b/%b want 0010/1", code, note_strobe);
                end
            end
        end
        checks++;
        if (ns !== 2) begin
            errors++;
            $display("FAIL chord_strobes got %0d want 2", ns);
        end
    endtask

    task automatic test_hold_press();
        int blanks = 0;
        key = 8'h00;
        for (int e = 0; e <= int'(D + H) + 6; e++) begin
            if (e == int'(H) - 1) key = 8'h04;
            tick();
            if (code === 4'b0000 || note_valid !== 1'b1) blanks++;
            checks++;
            if (code !== m_code || note_valid !== m_valid || note_strobe !== m_strobe) begin
                errors++;
                $display("FAIL holdpress_model e=%0d got %b/%b/%b want %b/%b/%b",
                         e, code, note_valid, note_strobe, m_code, m_valid, m_strobe);
            end
            if (e == int'(D + H) + 3) begin
                checks++;
                if (code !== 4'b0100 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL holdpress_load got %b/%b want 0100/1", code, note_strobe);
                end
            end
        end
        checks++;
        if (blanks !== 0) begin
            errors++;
            $display("FAIL holdpress_blank got %0d blank cycles want 0", blanks);
        end
    endtask

    task automatic test_reset_mid();
        int ns = 0;
        settle(int'(D + H) + 8);
        key = 8'h20;
        repeat (D + 6) tick();
        @(posedge clk);
        model_step();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (code !== 4'b0000 || note_valid !== 1'b0 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%b want 0000/0/0", code, note_valid, note_strobe);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (note_strobe === 1'b1) ns++;
            checks++;
            if (code !== m_code || note_valid !== m_valid || note_strobe !== m_strobe) begin
                errors++;
                $display("FAIL rstheld_model e=%0d got %b/%b/%b want %b/%b/%b",
                         e, code, note_valid, note_strobe, m_code, m_valid, m_strobe);
            end
        end
        checks++;
        if (ns !== 0 || note_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstheld_nostrobe got strobes=%0d valid=%b want 0/0", ns, note_valid);
        end
        settle(int'(D) + 6);
        key = 8'h20;
        for (int e = 0; e <= int'(D) + 6; e++) begin
            tick();
            if (e == int'(D) + 4) begin
                checks++;
                if (code !== 4'b0111 || note_strobe !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_repress got %b/%b want 0111/1", code, note_strobe);
                end
            end
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        int len;
        while (cyc < 800) begin
            key = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, D));
            else len = int'($urandom_range(D + 2, 2 * D + H + 4));
            for (int e = 0; e < len; e++) begin
                tick();
                cyc++;
                checks++;
                if (code !== m_code || note_valid !== m_valid || note_strobe !== m_strobe) begin
                    errors++;
                    $display("FAIL random_model cyc=%0d key=%h got %b/%b/%b want %b/%b/%b",
                             cyc, key, code, note_valid, note_strobe,
                             m_code, m_valid, m_strobe);
                end
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        settle(int'(D + H) + 8);
        test_chord();
        test_hold_press();
        test_reset_mid();
        settle(int'(D + H) + 8);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
